normalize_pack: RTL and testbench
=================================

Name: normalize_pack

Overview:
- Post-normalization stage of the half-precision (IEEE 754 binary16) adder datapath; the counterpart to the operand pre-alignment stage.
- Takes the sign, the common biased exponent and the unnormalized mantissa sum/difference produced after alignment and add/subtract.
- Normalizes iteratively (one shift per cycle), optionally rounds, and packs a 16-bit result.
- Uses a valid/ready handshake on both sides.

Parameters:
- EXP_W, 5, exponent field width; max exponent code = 2^EXP_W-1 (31).
- FRAC_W, 10, fraction field width; mant_in width = FRAC_W+4, result width = 1+EXP_W+FRAC_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept; high only in IDLE.
- sign_in  in  1  result sign.
- exp_in  in  EXP_W  biased exponent of aligned operands.
- mant_in  in  FRAC_W+4  bit13 carry, bit12 hidden, bits11:2 fraction, bit1 guard, bit0 sticky.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+FRAC_W  packed {sign, exp, frac}.
- overflow  out  1  result saturated to infinity.
- underflow  out  1  result is subnormal or zero from nonzero input.

Behaviour:
- Reset: state=IDLE; in_ready=1, out_valid=0, result=0, overflow=0, underflow=0. rst wins over every other event; a reset mid-operation discards the in-flight operand.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - Accept on in_valid&in_ready; register sign, exp, mant (m).
  - mant_in==0 -> result=0x0000 (positive zero, including sign_in=1), flags 0, go DONE.
  - exp_in==31 -> result={sign,31,0}, overflow=1, go DONE.
  - Otherwise go NORM.
- NORM, one action per cycle:
  - m[13]=1: m={0, m[13:2], m[1]|m[0]}, exp+1. If the new exp==31, set result=inf and overflow=1, go DONE; else go ROUND.
  - m[12]=0 and exp>1: m<<=1, exp-1, stay in NORM.
  - m[12]=0 and exp<=1: exp=0, underflow=1, go ROUND (subnormal, no further shift).
  - m[12]=1: go ROUND.
- ROUND: packs {sign, exp, m[11:2]}; rounding behaviour per the Optional Feature. Go DONE.
- DONE: out_valid=1, result and flags stable. Hold until out_ready=1, then go IDLE next cycle (out_valid drops, flags clear).
- in_ready=0 in NORM, ROUND and DONE; no input is accepted while a result is pending.
- Latency from accept edge to out_valid:
  - 3 cycles with no left shift (IDLE->NORM->ROUND->DONE).
  - 3+k with k left shifts; k is at most 12 and bounded by exp-1.
  - 1 cycle for the zero/exp31 fast paths.
- Throughput: at most one result per latency+1 cycles (no overlap).
- Width rules: exp arithmetic is EXP_W+1 bits internally so overflow detection cannot wrap; the fraction increment carries into the exponent.

Optional Feature:
- Macro: NORMALIZE_PACK_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even in ROUND. Increment the 15-bit {exp,frac} when guard & (sticky | frac[0]).
  - Carry into exp 31 -> inf, overflow=1.
  - A subnormal rounding up to exp=1 is a normal number; clear underflow.
- Undefined: truncation; guard and sticky are ignored in ROUND (sticky still accumulates on right shift). ROUND never changes exp.

Test Plan:
- sign=0, exp=15, mant=0x1000 -> result 0x3C00, flags 0, out_valid exactly 3 cycles after the accept edge.
- exp=15, mant=0x2000 (carry) -> result 0x4000 after 3 cycles.
- exp=15, mant=0x0004 (cancellation) -> 10 NORM shifts, result 0x1400, out_valid at 13 cycles.
- exp=30, mant=0x2000 -> result 0x7C00, overflow=1.
- exp=1, mant=0x0800 -> 0x0200, underflow=1.
- mant_in=0 with sign=1 -> 0x0000 after 1 cycle.
- exp=15, mant=0x1006: with macro 0x3C02, without 0x3C01. Hold out_ready=0 for 5 cycles: result stable, in_ready=0, new in_valid ignored; assert rst during NORM -> next cycle state IDLE and all outputs at reset values.

Source files
------------

// File: rtl/normalize_pack.sv
// Post-normalization and packing stage of the binary16 adder datapath: one shift per cycle,
// then pack. Optional round-to-nearest-even is enabled by NORMALIZE_PACK_ROUND_NEAREST_EN.
module normalize_pack #(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [FRAC_W+3:0]       mant_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int MW = FRAC_W + 4;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_sign;
    logic [EXP_W:0]      r_exp;
    logic [MW-1:0]       r_mant;

    logic [EXP_W:0]      w_exp_inc;
    logic [FRAC_W-1:0]   w_frac;
    logic [EXP_W+FRAC_W-1:0] w_inf_mag;

    assign w_exp_inc = r_exp + EXP_ONE;
    assign w_frac    = r_mant[MW-3:2];
    assign w_inf_mag = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};

`ifdef NORMALIZE_PACK_ROUND_NEAREST_EN
    logic                      w_round_up;
    logic [EXP_W+FRAC_W:0]     w_rounded;

    // Incrementing the packed {exp,frac} lets a fraction carry ripple into the exponent.
    assign w_round_up = r_mant[1] & (r_mant[0] | w_frac[0]);
    assign w_rounded  = {1'b0, r_exp[EXP_W-1:0], w_frac} + {{(EXP_W+FRAC_W){1'b0}}, 1'b1};
`endif

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sign    <= 1'b0;
            r_exp     <= '0;
            r_mant    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_sign    <= sign_in;
                        r_exp     <= {1'b0, exp_in};
                        r_mant    <= mant_in;
                        in_ready  <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        if (mant_in == '0) begin
                            result    <= '0;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else if ({1'b0, exp_in} == EXP_MAX) begin
                            result    <= {sign_in, w_inf_mag};
                            overflow  <= 1'b1;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_NORM;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_NORM: begin
                    if (r_mant[MW-1]) begin
                        // Carry out: shift right once, folding the dropped bits into sticky.
                        r_mant <= {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
                        r_exp  <= w_exp_inc;
                        if (w_exp_inc >= EXP_MAX) begin
                            result    <= {r_sign, w_inf_mag};
                            overflow  <= 1'b1;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_ROUND;
                        end
                    end else if (!r_mant[MW-2]) begin
                        if (r_exp > EXP_ONE) begin
                            r_mant <= {r_mant[MW-2:0], 1'b0};
                            r_exp  <= r_exp - EXP_ONE;
                        end else begin
                            r_exp     <= '0;
                            underflow <= 1'b1;
                            r_state   <= S_ROUND;
                        end
                    end else begin
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
`ifdef NORMALIZE_PACK_ROUND_NEAREST_EN
                    if (w_round_up) begin
                        if (w_rounded[EXP_W+FRAC_W:FRAC_W] >= EXP_MAX) begin
                            result   <= {r_sign, w_inf_mag};
                            overflow <= 1'b1;
                        end else begin
                            result    <= {r_sign, w_rounded[EXP_W+FRAC_W-1:0]};
                            underflow <= underflow & (w_rounded[EXP_W+FRAC_W:FRAC_W] == '0);
                        end
                    end else begin
                        result <= {r_sign, r_exp[EXP_W-1:0], w_frac};
                    end
`else
                    result <= {r_sign, r_exp[EXP_W-1:0], w_frac};
`endif
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_pack.sv
// Self-checking bench for normalize_pack: vector table driven through a scoreboard queue,
// plus hand-written stall and mid-operation reset sequences.
module tb_normalize_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [13:0] mant_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [13:0] m;
        logic [15:0] r;
        logic        ov;
        logic        un;
        int          lat;
    } vec_t;

    vec_t vecs[12];
    vec_t sb[$];

    normalize_pack #(.EXP_W(5), .FRAC_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Present one operand, wait for its result, compare against the scoreboard entry.
    task automatic run_vec(input vec_t v, input bit release_out);
        int   w;
        int   lat;
        vec_t e;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        sign_in  = v.s;
        exp_in   = v.e;
        mant_in  = v.m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(v);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("result", {16'd0, result}, {16'd0, e.r});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
            chk("underflow", {31'd0, underflow}, {31'd0, e.un});
            chk("latency", lat, e.lat);
        end else begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_result"},    {16'd0, result},    32'd0);
        chk({tag, "_overflow"},  {31'd0, overflow},  32'd0);
        chk({tag, "_underflow"}, {31'd0, underflow}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd15, 14'h1000, 16'h3C00, 1'b0, 1'b0, 3};
        vecs[1]  = '{1'b0, 5'd15, 14'h2000, 16'h4000, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b0, 5'd15, 14'h0004, 16'h1400, 1'b0, 1'b0, 13};
        vecs[3]  = '{1'b0, 5'd30, 14'h2000, 16'h7C00, 1'b1, 1'b0, 2};
        vecs[4]  = '{1'b0, 5'd1,  14'h0800, 16'h0200, 1'b0, 1'b1, 3};
        vecs[5]  = '{1'b1, 5'd15, 14'h0000, 16'h0000, 1'b0, 1'b0, 1};
        vecs[6]  = '{1'b1, 5'd31, 14'h1000, 16'hFC00, 1'b1, 1'b0, 1};
        vecs[8]  = '{1'b1, 5'd10, 14'h2003, 16'hAC00, 1'b0, 1'b0, 3};
        vecs[9]  = '{1'b0, 5'd3,  14'h0100, 16'h0100, 1'b0, 1'b1, 5};
`ifdef NORMALIZE_PACK_ROUND_NEAREST_EN
        vecs[7]  = '{1'b0, 5'd15, 14'h1006, 16'h3C02, 1'b0, 1'b0, 3};
        vecs[10] = '{1'b0, 5'd30, 14'h1FFE, 16'h7C00, 1'b1, 1'b0, 3};
        vecs[11] = '{1'b0, 5'd1,  14'h0FFE, 16'h0400, 1'b0, 1'b0, 3};
`else
        vecs[7]  = '{1'b0, 5'd15, 14'h1006, 16'h3C01, 1'b0, 1'b0, 3};
        vecs[10] = '{1'b0, 5'd30, 14'h1FFE, 16'h7BFF, 1'b0, 1'b0, 3};
        vecs[11] = '{1'b0, 5'd1,  14'h0FFE, 16'h03FF, 1'b0, 1'b1, 3};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        sign_in   = 1'b0;
        exp_in    = 5'd0;
        mant_in   = 14'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], 1'b1);
        end

        // Consumer stall: result held, no new operand accepted.
        run_vec(vecs[0], 1'b0);
        sign_in  = 1'b1;
        exp_in   = 5'd20;
        mant_in  = 14'h2000;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_result", {16'd0, result}, 32'h3C00);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a long normalization.
        sign_in  = 1'b0;
        exp_in   = 5'd15;
        mant_in  = 14'h0004;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("norm_busy_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_outputs("midreset");
        repeat (15) @(posedge clk);
        #1;
        chk("midreset_no_stale_out", {31'd0, out_valid}, 32'd0);

        run_vec(vecs[1], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
